// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the decode/issue side and the execute-stage ALU.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             out_err;

    modport master (
        output in_valid, alu_cnt, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, out_err
    );

    modport slave (
        input  in_valid, alu_cnt, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, out_err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative 1-bit-per-cycle
// shifts, valid/ready on both sides so writeback can stall without losing a result.
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [SHAMT_W-1:0] cnt_q,    cnt_d;
    logic [3:0]         sop_q,    sop_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q,   zero_d;
    logic               err_q,    err_d;
    logic               valid_q,  valid_d;

    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic               slt;
    logic [WIDTH-1:0]   acc_shifted;

    // in_ready looks only at our own state and the consumer's ready
    assign bus.in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    assign shamt = bus.op_b[SHAMT_W-1:0];
    assign sum   = bus.op_a + bus.op_b;
    assign diff  = bus.op_a - bus.op_b;
    assign slt   = $signed(bus.op_a) < $signed(bus.op_b);

    // One-bit step of the shift selected at accept time
    always_comb begin
        acc_shifted = acc_q;
        case (sop_q)
            OP_SLL:  acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
            OP_SRA:  acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_shifted = acc_q;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sop_d    = sop_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    case (bus.alu_cnt)
                        OP_AND: result_d = bus.op_a & bus.op_b;
                        OP_OR:  result_d = bus.op_a | bus.op_b;
                        OP_ADD: result_d = sum;
                        OP_SUB: result_d = diff;
                        OP_SLT: result_d = {{(WIDTH-1){1'b0}}, slt};
                        OP_SLL, OP_SRL, OP_SRA: begin
                            result_d = bus.op_a;
                            if (shamt != '0) begin
                                acc_d   = bus.op_a;
                                cnt_d   = shamt;
                                sop_d   = bus.alu_cnt;
                                state_d = S_SHIFT;
                            end
                        end
                        default: begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end
                    endcase
                    zero_d = (result_d == '0);
                end else if ((state_q == S_DONE) && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                acc_d = acc_shifted;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = acc_shifted;
                    zero_d   = (acc_shifted == '0);
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sop_q    <= OP_AND;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sop_q    <= sop_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases then random ops, each result
// compared with a plain-arithmetic reference model including expected latency.
module tb_alu_exec_unit;

    localparam int unsigned WIDTH = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_BAD = 4'b1111;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: result, error flag and cycles from accept to out_valid
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e, output int lat);
        int n;
        n   = int'(b[4:0]);
        e   = 1'b0;
        lat = 1;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL: r = a << n;
            OP_SRL: r = a >> n;
            OP_SRA: r = 32'($signed(a) >>> n);
            default: begin
                r = 32'd0;
                e = 1'b1;
            end
        endcase
        if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && n > 0) lat = n + 1;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        bus.alu_cnt  = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        #1;
        check1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.alu_cnt  = 4'($urandom);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] r;
        logic        e;
        int          lat;
        int          n;
        ref_alu(op, a, b, r, e, lat);
        issue(op, a, b, tag);
        if (lat > 1) check1({tag, "_busy_in_ready"}, bus.in_ready, 1'b0);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check32({tag, "_latency"}, 32'(n), 32'(lat));
        check32({tag, "_result"}, bus.result, r);
        check1({tag, "_zero"}, bus.zero, r == 32'd0);
        check1({tag, "_err"}, bus.out_err, e);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] q[$];
        logic        e;
        logic        seen;
        int          lat;
        logic [3:0]  opsel [0:8];
        logic [31:0] a;
        logic [31:0] b;

        opsel = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_SRL, OP_SRA, 4'b1011};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_cnt   = OP_AND;
        bus.op_a      = '0;
        bus.op_b      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check1("rst_out_valid", bus.out_valid, 1'b0);
        check32("rst_result", bus.result, 32'd0);
        check1("rst_zero", bus.zero, 1'b0);
        check1("rst_in_ready", bus.in_ready, 1'b1);

        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, "add_ovf");
        check32("add_ovf_abs", bus.result, 32'h8000_0000);
        do_op(OP_SUB, 32'd5, 32'd5, "sub_eq");
        check1("sub_eq_zero_abs", bus.zero, 1'b1);
        do_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        check32("slt_neg_abs", bus.result, 32'd1);
        do_op(OP_SLT, 32'd1, 32'hFFFF_FFFF, "slt_pos");

        do_op(OP_SRA, 32'h8000_0000, 32'd4, "sra4");
        check32("sra4_abs", bus.result, 32'hF800_0000);
        do_op(OP_SLL, 32'h1234_5678, 32'h0000_0020, "sll0");
        do_op(OP_SRL, 32'h8000_0001, 32'd31, "srl31");

        // Backpressure in DONE, then a same-cycle hand-off to a new op
        bus.out_ready = 1'b0;
        issue(OP_ADD, 32'd100, 32'd23, "bp");
        check1("bp_valid", bus.out_valid, 1'b1);
        check32("bp_result", bus.result, 32'd123);
        repeat (3) begin
            @(negedge clk);
            check1("bp_hold_valid", bus.out_valid, 1'b1);
            check32("bp_hold_result", bus.result, 32'd123);
            check1("bp_hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        issue(OP_AND, 32'hF0F0_FFFF, 32'h0FF0_1234, "bp_and");
        check1("bp_and_valid", bus.out_valid, 1'b1);
        check32("bp_and_result", bus.result, 32'h00F0_1234);
        @(negedge clk);
        check1("bp_and_drain", bus.out_valid, 1'b0);

        // Four back-to-back ADDs
        q = {};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                check1("stream_valid", bus.out_valid, 1'b1);
                check32("stream_result", bus.result, q.pop_front());
            end
            if (i < 4) begin
                a = $urandom;
                b = $urandom;
                q.push_back(a + b);
                bus.alu_cnt  = OP_ADD;
                bus.op_a     = a;
                bus.op_b     = b;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check1("stream_end", bus.out_valid, 1'b0);

        do_op(OP_BAD, 32'hDEAD_BEEF, 32'h1, "illegal");
        check1("illegal_err_abs", bus.out_err, 1'b1);

        // Reset in the middle of a long shift discards it
        issue(OP_SLL, 32'h0000_0001, 32'd20, "abort");
        repeat (5) @(negedge clk);
        check1("abort_busy", bus.out_valid, 1'b0);
        rst = 1'b1;
        #1;
        check1("abort_rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check1("abort_no_valid", seen, 1'b0);
        check32("abort_result", bus.result, 32'd0);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : 32'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            do_op(opsel[$urandom_range(0, 8)], a, b, "rand");
        end
        ref_alu(OP_SRA, 32'h4000_0000, 32'd3, r, e, lat);
        do_op(OP_SRA, 32'h4000_0000, 32'd3, "sra_pos");
        check32("sra_pos_abs", bus.result, 32'h0800_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
